// File: rtl/ysyx_22040750_lsu_pkg.sv
// Shared store-aligner types. The hi/shi/cross entry fields exist only with
// YSYX_22040750_ST_SPLIT_EN defined.
package ysyx_22040750_lsu_pkg;

  localparam int unsigned LSU_DATA_W = 64;
  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_STRB_W = LSU_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } st_size_e;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } st_state_e;

  // One queued store, already lane-positioned at push time.
  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] lo;
    logic [LSU_STRB_W-1:0] slo;
`ifdef YSYX_22040750_ST_SPLIT_EN
    logic [LSU_DATA_W-1:0] hi;
    logic [LSU_STRB_W-1:0] shi;
    logic                  cross;
`endif
  } st_entry_t;

endpackage

// File: rtl/ysyx_22040750_st_lane_shift.sv
// Combinational lane positioner for one store; the upper (hi) half is produced
// only with YSYX_22040750_ST_SPLIT_EN defined.
module ysyx_22040750_st_lane_shift
  import ysyx_22040750_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [$clog2(DATA_W/8)-1:0] I_off,
  input  logic [1:0]                  I_size,
  input  logic [DATA_W-1:0]           I_data,
  output logic [DATA_W-1:0]           O_lo,
  output logic [DATA_W/8-1:0]         O_slo,
`ifdef YSYX_22040750_ST_SPLIT_EN
  output logic [DATA_W-1:0]           O_hi,
  output logic [DATA_W/8-1:0]         O_shi,
`endif
  output logic                        O_cross
);

  localparam int unsigned B = DATA_W / 8;

  logic [B-1:0]      bmask_s;
  logic [DATA_W-1:0] dmask_s;
  logic [2*B-1:0]    swide_s;

  // Byte mask of the first n bytes; n saturates at B because i never reaches B.
  always_comb begin
    bmask_s = '0;
    dmask_s = '0;
    for (int i = 0; i < int'(B); i++) begin
      if (i < (32'sd1 <<< I_size)) begin
        bmask_s[i]        = 1'b1;
        dmask_s[8*i +: 8] = 8'hFF;
      end else begin
        bmask_s[i]        = 1'b0;
        dmask_s[8*i +: 8] = 8'h00;
      end
    end
  end

  assign swide_s = {{B{1'b0}}, bmask_s} << I_off;
  assign O_slo   = swide_s[B-1:0];
  assign O_cross = |swide_s[2*B-1:B];

`ifdef YSYX_22040750_ST_SPLIT_EN
  logic [2*DATA_W-1:0] dwide_s;
  assign dwide_s = {{DATA_W{1'b0}}, (I_data & dmask_s)} << {I_off, 3'b000};
  assign O_lo    = dwide_s[DATA_W-1:0];
  assign O_hi    = dwide_s[2*DATA_W-1:DATA_W];
  assign O_shi   = swide_s[2*B-1:B];
`else
  assign O_lo    = (I_data & dmask_s) << {I_off, 3'b000};
`endif

endmodule

// File: rtl/ysyx_22040750_st_align_buf.sv
// Store aligner and request queue. With YSYX_22040750_ST_SPLIT_EN defined,
// bus-word-crossing stores become two beats; otherwise they are dropped and flagged.
module ysyx_22040750_st_align_buf
  import ysyx_22040750_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                I_sys_clk,
  input  logic                I_rst_n,
  input  logic                I_req_valid,
  output logic                O_req_ready,
  input  logic [ADDR_W-1:0]   I_req_addr,
  input  logic [DATA_W-1:0]   I_req_data,
  input  logic [1:0]          I_req_size,
  output logic                O_wr_valid,
  input  logic                I_wr_ready,
  output logic [ADDR_W-1:0]   O_wr_addr,
  output logic [DATA_W-1:0]   O_wr_data,
  output logic [DATA_W/8-1:0] O_wr_strb,
  output logic                O_misalign,
  output logic                O_busy
);

  localparam int unsigned B     = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  st_entry_t          mem_q [DEPTH];
  st_entry_t          mem_d [DEPTH];
  st_entry_t          new_s;
  st_entry_t          head_s;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  lo_s;
  logic [B-1:0]       slo_s;
  logic               cross_s;
  logic               req_ready_s, wr_valid_s, push_s, hs_s, enq_s, pop_s;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic [B-1:0]       wr_strb_s;

`ifdef YSYX_22040750_ST_SPLIT_EN
  logic [DATA_W-1:0]  hi_s;
  logic [B-1:0]       shi_s;
  st_state_e          state_q, state_d;
`else
  logic               misalign_q, misalign_d;
`endif

  ysyx_22040750_st_lane_shift #(.DATA_W(DATA_W)) u_lane_shift (
    .I_off   (I_req_addr[OFF_W-1:0]),
    .I_size  (I_req_size),
    .I_data  (I_req_data),
    .O_lo    (lo_s),
    .O_slo   (slo_s),
`ifdef YSYX_22040750_ST_SPLIT_EN
    .O_hi    (hi_s),
    .O_shi   (shi_s),
`endif
    .O_cross (cross_s)
  );

  assign head_s = mem_q[rd_ptr_q];

  // Ready depends on occupancy only, so a full queue refuses even during a pop.
  always_comb begin
    req_ready_s = (cnt_q < FULL_CNT);
    wr_valid_s  = (cnt_q != '0);
    push_s      = I_req_valid && req_ready_s;
    hs_s        = wr_valid_s && I_wr_ready;
`ifdef YSYX_22040750_ST_SPLIT_EN
    enq_s       = push_s;
    pop_s       = hs_s && ((state_q == S_HI) || !head_s.cross);
`else
    enq_s       = push_s && !cross_s;
    pop_s       = hs_s;
    misalign_d  = push_s && cross_s;
`endif
    wr_ptr_d    = wr_ptr_q + PTR_W'(enq_s);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_s);
    cnt_d       = cnt_q + CNT_W'(enq_s) - CNT_W'(pop_s);
  end

  always_comb begin
    new_s       = '0;
    new_s.addr  = LSU_ADDR_W'({I_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
    new_s.lo    = LSU_DATA_W'(lo_s);
    new_s.slo   = LSU_STRB_W'(slo_s);
`ifdef YSYX_22040750_ST_SPLIT_EN
    new_s.hi    = LSU_DATA_W'(hi_s);
    new_s.shi   = LSU_STRB_W'(shi_s);
    new_s.cross = cross_s;
`endif
    mem_d = mem_q;
    if (enq_s) begin
      mem_d[wr_ptr_q] = new_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef YSYX_22040750_ST_SPLIT_EN
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LO: begin
        if (hs_s && head_s.cross) state_d = S_HI;
        else                      state_d = S_LO;
      end
      S_HI: begin
        if (hs_s) state_d = S_LO;
        else      state_d = S_HI;
      end
      default: state_d = S_LO;
    endcase
  end
`else
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  // Beat outputs are forced to zero whenever nothing is queued.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    wr_strb_s = '0;
    if (wr_valid_s) begin
`ifdef YSYX_22040750_ST_SPLIT_EN
      if (state_q == S_HI) begin
        wr_addr_s = ADDR_W'(head_s.addr) + ADDR_W'(B);
        wr_data_s = DATA_W'(head_s.hi);
        wr_strb_s = B'(head_s.shi);
      end else begin
        wr_addr_s = ADDR_W'(head_s.addr);
        wr_data_s = DATA_W'(head_s.lo);
        wr_strb_s = B'(head_s.slo);
      end
`else
      wr_addr_s = ADDR_W'(head_s.addr);
      wr_data_s = DATA_W'(head_s.lo);
      wr_strb_s = B'(head_s.slo);
`endif
    end else begin
      wr_addr_s = '0;
      wr_data_s = '0;
      wr_strb_s = '0;
    end
  end

  assign O_req_ready = req_ready_s;
  assign O_wr_valid  = wr_valid_s;
  assign O_busy      = wr_valid_s;
  assign O_wr_addr   = wr_addr_s;
  assign O_wr_data   = wr_data_s;
  assign O_wr_strb   = wr_strb_s;
`ifdef YSYX_22040750_ST_SPLIT_EN
  assign O_misalign  = 1'b0;
`else
  assign O_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22040750_st_align_buf.sv
// Directed plus randomized bench for ysyx_22040750_st_align_buf against a
// byte-level beat-queue model; follows YSYX_22040750_ST_SPLIT_EN like the RTL.
module tb_ysyx_22040750_st_align_buf;
  import ysyx_22040750_lsu_pkg::*;

  localparam int DEPTH = 2;
  localparam int B     = 8;
`ifdef YSYX_22040750_ST_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        misalign, busy;

  int ncmp = 0;
  int nerr = 0;

  ysyx_22040750_st_align_buf #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .I_sys_clk  (clk),
    .I_rst_n    (rst_n),
    .I_req_valid(req_valid),
    .O_req_ready(req_ready),
    .I_req_addr (req_addr),
    .I_req_data (req_data),
    .I_req_size (req_size),
    .O_wr_valid (wr_valid),
    .I_wr_ready (wr_ready),
    .O_wr_addr  (wr_addr),
    .O_wr_data  (wr_data),
    .O_wr_strb  (wr_strb),
    .O_misalign (misalign),
    .O_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    req_cnt = 0;
  bit    mis_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: place each of the n bytes at byte position off+i of a two-word window.
  task automatic model_push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    beat_t b0, b1;
    int off, n;
    off = int'(a % 32'd8);
    n = 1 << sz;
    if (n > B) n = B;
    b0.addr = a - 32'(off);
    b1.addr = a - 32'(off) + 32'd8;
    b0.data = '0; b0.strb = '0; b0.last = 1'b1;
    b1.data = '0; b1.strb = '0; b1.last = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (off + i < B) begin
        b0.data[(off+i)*8 +: 8] = d[i*8 +: 8];
        b0.strb[off+i] = 1'b1;
      end else begin
        b1.data[(off+i-B)*8 +: 8] = d[i*8 +: 8];
        b1.strb[off+i-B] = 1'b1;
      end
    end
    if (off + n > B) begin
      if (SPLIT) begin
        b0.last = 1'b0;
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        req_cnt++;
      end else begin
        mis_exp = 1'b1;
      end
    end else begin
      exp_q.push_back(b0);
      req_cnt++;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    req_cnt = 0;
    mis_exp = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  // One clock: compare outputs against the model, then advance both across the edge.
  task automatic cycle();
    bit push, pop;
    beat_t h;
    #1;
    chk("ready", req_ready, 64'(req_cnt < DEPTH));
    chk("valid", wr_valid, 64'(exp_q.size() != 0));
    chk("busy", busy, 64'(exp_q.size() != 0));
    chk("misalign", misalign, 64'(mis_exp));
    if (exp_q.size() != 0) begin
      chk("addr", wr_addr, exp_q[0].addr);
      chk("data", wr_data, exp_q[0].data);
      chk("strb", wr_strb, exp_q[0].strb);
    end
    push = req_valid && (req_cnt < DEPTH);
    pop  = (exp_q.size() != 0) && wr_ready;
    @(posedge clk);
    mis_exp = 1'b0;
    if (pop) begin
      h = exp_q.pop_front();
      if (h.last) req_cnt--;
    end
    if (push) model_push(req_addr, req_data, req_size);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0, SZ_B);
    #12;
    chk("rst_valid", wr_valid, 64'h0);
    chk("rst_addr", wr_addr, 64'h0);
    chk("rst_data", wr_data, 64'h0);
    chk("rst_strb", wr_strb, 64'h0);
    chk("rst_misalign", misalign, 64'h0);
    chk("rst_busy", busy, 64'h0);
    chk("rst_ready", req_ready, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sd, aligned
    drive(1'b1, 32'h8000_0000, 64'h1122_3344_5566_7788, SZ_D);
    cycle();
    req_valid = 1'b0;
    chk("sd_valid", wr_valid, 64'h1);
    chk("sd_addr", wr_addr, 64'h8000_0000);
    chk("sd_data", wr_data, 64'h1122_3344_5566_7788);
    chk("sd_strb", wr_strb, 64'hFF);
    cycle();

    // sb with junk above the byte
    drive(1'b1, 32'h8000_0005, 64'h5555_5555_5555_55AB, SZ_B);
    cycle();
    req_valid = 1'b0;
    chk("sb_addr", wr_addr, 64'h8000_0000);
    chk("sb_data", wr_data, 64'h0000_AB00_0000_0000);
    chk("sb_strb", wr_strb, 64'h20);
    cycle();

    // sw crossing the bus word
    drive(1'b1, 32'h8000_0006, 64'h1234_5678_DEAD_BEEF, SZ_W);
    cycle();
    req_valid = 1'b0;
`ifdef YSYX_22040750_ST_SPLIT_EN
    chk("sw_b1_addr", wr_addr, 64'h8000_0000);
    chk("sw_b1_data", wr_data, 64'hBEEF_0000_0000_0000);
    chk("sw_b1_strb", wr_strb, 64'hC0);
    cycle();
    chk("sw_b2_addr", wr_addr, 64'h8000_0008);
    chk("sw_b2_data", wr_data, 64'h0000_0000_0000_DEAD);
    chk("sw_b2_strb", wr_strb, 64'h03);
    cycle();
    chk("sw_done", wr_valid, 64'h0);
`else
    chk("sw_nobeat", wr_valid, 64'h0);
    chk("sw_mis_pulse", misalign, 64'h1);
    cycle();
    chk("sw_mis_end", misalign, 64'h0);
`endif
    cycle();

    // Back-pressure with a full queue
    wr_ready = 1'b0;
    drive(1'b1, 32'h8000_0010, 64'h11, SZ_B);
    cycle();
    drive(1'b1, 32'h8000_0011, 64'h22, SZ_B);
    cycle();
    chk("full_ready", req_ready, 64'h0);
    drive(1'b1, 32'h8000_0012, 64'h33, SZ_B);
    repeat (3) cycle();
    chk("stall_strb", wr_strb, 64'h01);
    chk("stall_data", wr_data, 64'h11);
    wr_ready = 1'b1;
    cycle();
    chk("after_pop_ready", req_ready, 64'h1);
    cycle();
    req_valid = 1'b0;
    chk("third_strb", wr_strb, 64'h04);
    chk("third_data", wr_data, 64'h0000_0000_0033_0000);
    cycle();
    chk("drained", wr_valid, 64'h0);

    // Randomized traffic, including addresses near the top for wrap-around
    for (int k = 0; k < 400; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      wr_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        req_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        req_addr = 32'h8000_0000 + 32'($urandom_range(0, 63));
      req_data = {$urandom, $urandom};
      req_size = 2'($urandom_range(0, 3));
      cycle();
    end
    req_valid = 1'b0;
    wr_ready  = 1'b1;
    repeat (6) cycle();
    chk("rand_drained", wr_valid, 64'h0);

    // Asynchronous reset with a beat still pending
`ifdef YSYX_22040750_ST_SPLIT_EN
    drive(1'b1, 32'h8000_0006, 64'h0000_0000_CAFE_F00D, SZ_W);
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("mid_split_addr", wr_addr, 64'h8000_0008);
`else
    drive(1'b1, 32'h8000_0000, 64'h0000_0000_CAFE_F00D, SZ_D);
    cycle();
    req_valid = 1'b0;
    wr_ready  = 1'b0;
    cycle();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", wr_valid, 64'h0);
    chk("arst_addr", wr_addr, 64'h0);
    chk("arst_data", wr_data, 64'h0);
    chk("arst_strb", wr_strb, 64'h0);
    chk("arst_misalign", misalign, 64'h0);
    chk("arst_busy", busy, 64'h0);
    chk("arst_ready", req_ready, 64'h1);
    model_clear();
    #3;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 64'h0);
    chk("post_rst_ready", req_ready, 64'h1);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_st_align_buf.md
# ysyx_22040750_st_align_buf

Store-path write aligner and buffer between the LSU execute stage and the data-memory/AXI write channel. Accepts byte/half/word/dword store requests with a byte address, produces bus-aligned write beats with byte strobes, and buffers up to DEPTH requests. Stores that cross a bus-word boundary are split into two beats, or flagged when the split feature is compiled out.

## Interface
Parameters:
- DATA_W, 64: bus data width; power of two, 32 or 64.
- ADDR_W, 32: address width.
- DEPTH, 2: request queue entries; power of two, at least 2.

Ports:
- I_sys_clk  in  1  clock, rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_req_valid  in  1  store request valid.
- O_req_ready  out  1  request accepted when valid and ready are both high.
- I_req_addr  in  ADDR_W  byte address.
- I_req_data  in  DATA_W  store data, LSB-justified.
- I_req_size  in  2  log2 of byte count: 0 byte, 1 half, 2 word, 3 dword.
- O_wr_valid  out  1  write beat valid.
- I_wr_ready  in  1  write beat accepted.
- O_wr_addr  out  ADDR_W  beat address, aligned to DATA_W/8.
- O_wr_data  out  DATA_W  lane-positioned write data.
- O_wr_strb  out  DATA_W/8  byte strobes.
- O_misalign  out  1  one-cycle pulse: boundary-crossing store dropped (macro off only).
- O_busy  out  1  queue non-empty or beat in flight.

## Operation
- B = DATA_W/8, off = addr mod B, n = 1 << size. If n > B, n is clamped to B.
- Lane shift: the 2*DATA_W value {hi,lo} = zero-extended data masked to n bytes, shifted left by off*8. The 2*B strobe {shi,slo} = ((1<<n)-1) << off.
- Cross = shi != 0, i.e. off+n > B.
- Entry fields: aligned addr, lo, slo, hi, shi, cross. Stored on push.
- O_req_ready = (count < DEPTH). It does not depend on I_wr_ready; a full queue refuses a request even if a pop happens in the same cycle.
- Output FSM, two states:
  - S_LO: presents the head entry's aligned addr, lo, slo.
    - On handshake, if cross, go to S_HI.
    - Otherwise pop the entry and stay in S_LO.
  - S_HI: presents aligned addr + B, hi, shi. On handshake, pop and return to S_LO.
- The address increment wraps modulo 2^ADDR_W.
- Unused lanes of O_wr_data are zero.
- O_wr_valid = (count != 0).
- O_busy = O_wr_valid.

## Timing
- Reset, asynchronous: count 0, pointers 0, state S_LO.
  - O_wr_valid, O_wr_addr, O_wr_data, O_wr_strb, O_misalign and O_busy are all 0.
  - O_req_ready is 1.
- Reset asserted mid-split discards all entries, including a pending hi beat.
- Latency: a request accepted at edge k gives O_wr_valid high after edge k, if the queue was empty.
- Throughput: one beat per cycle when I_wr_ready is held high. A split store takes two cycles.
- While O_wr_valid=1 and I_wr_ready=0, O_wr_addr, O_wr_data and O_wr_strb stay stable.
- Simultaneous push and pop on a non-full queue leaves count unchanged.

## Configuration
- YSYX_22040750_ST_SPLIT_EN defined: crossing stores are split as described above. O_misalign is tied to 0.
- Undefined:
  - A crossing store is still handshaken, so O_req_ready gates it as usual, but it is not enqueued.
  - O_misalign pulses 1 the cycle after acceptance.
  - The S_HI state and the hi/shi storage are removed.
  - Non-crossing unaligned stores are written normally.

## Structure
- Package ysyx_22040750_lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the output state enum (S_LO, S_HI);
  - the entry struct typedef, parameterised via localparams.
- Sub-module ysyx_22040750_st_lane_shift: combinational; takes addr offset, size and data, and returns {hi,lo}, {shi,slo} and cross. It is instantiated once on the push side.

## Test plan
- sd 0x1122334455667788 at 0x80000000, wr_ready=1:
  - one beat next cycle at addr 0x80000000, data 0x1122334455667788, strb 0xFF.
- sb 0xAB at 0x80000005:
  - beat at 0x80000000, data 0x0000AB0000000000, strb 0x20.
- sw 0xDEADBEEF at 0x80000006, split enabled:
  - beat 1: addr 0x80000000, data 0xBEEF000000000000, strb 0xC0;
  - beat 2: addr 0x80000008, data 0x000000000000DEAD, strb 0x03.
- Same sw with the macro off:
  - req accepted, no beat, O_misalign=1 for exactly one cycle.
- wr_ready=0, push three sb requests (DEPTH=2):
  - O_req_ready drops after the second request;
  - the third is held until one pop;
  - the output is stable throughout the stall.
- Assert I_rst_n low between beat 1 and beat 2 of a split:
  - all outputs 0 immediately;
  - after release, O_busy=0 and O_req_ready=1.
